// File: rtl/hilo_muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit owning the HI/LO register pair.
// Define MULDIV_FAST_MUL_EN to let MUL stop once the remaining multiplier bits are zero.
`timescale 1ns/1ps
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             to_lh,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       lh_to_reg,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] lh_dout,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   acc, mcand, acc_nx;
    logic [WIDTH-1:0]     mplier, mplier_nx;
    logic [WIDTH-1:0]     rem, quot, divisor, rem_nx, quot_nx;
    logic [WIDTH:0]       shifted;
    logic [CNT_W-1:0]     cnt;
    logic                 dz;
    logic                 start_mul, start_div, cnt_last, mul_last, finish;

    assign start_mul = to_lh && (alu_op == OP_MULTU);
    assign start_div = to_lh && (alu_op == OP_DIVU);
    assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));

    // Multiplicand shifts left so early termination leaves the product complete
    assign acc_nx    = acc + (mplier[0] ? mcand : '0);
    assign mplier_nx = mplier >> 1;
`ifdef MULDIV_FAST_MUL_EN
    assign mul_last  = cnt_last || (mplier_nx == '0);
`else
    assign mul_last  = cnt_last;
`endif

    // Restoring step: the difference is below 2^WIDTH whenever it is kept
    assign shifted = {rem, quot[WIDTH-1]};
    assign rem_nx  = (shifted >= {1'b0, divisor}) ? (shifted[WIDTH-1:0] - divisor)
                                                  : shifted[WIDTH-1:0];
    assign quot_nx = {quot[WIDTH-2:0], (shifted >= {1'b0, divisor})};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        finish   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_mul)      state_nx = S_MUL;
                else if (start_div) state_nx = S_DIV;
            end
            S_MUL: begin
                if (mul_last) begin
                    finish   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DIV: begin
                if (dz || cnt_last) begin
                    finish   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            cnt     <= '0;
            dz      <= 1'b0;
        end else begin
            done <= finish;
            case (state)
                S_IDLE: begin
                    if (start_mul) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, src_a};
                        mplier <= src_b;
                        cnt    <= '0;
                    end else if (start_div) begin
                        rem     <= '0;
                        quot    <= src_a;
                        divisor <= src_b;
                        dz      <= (src_b == '0);
                        cnt     <= '0;
                    end
                end
                S_MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nx;
                    cnt    <= cnt + CNT_W'(1);
                    if (finish) {hi, lo} <= acc_nx;
                end
                S_DIV: begin
                    rem  <= rem_nx;
                    quot <= quot_nx;
                    cnt  <= cnt + CNT_W'(1);
                    // On divide-by-zero no step has run yet, so quot still holds the dividend
                    if (finish) begin
                        if (dz) begin
                            lo <= '1;
                            hi <= quot;
                        end else begin
                            lo <= quot_nx;
                            hi <= rem_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign stall = busy && (lh_to_reg != 2'b00);

    always_comb begin
        lh_dout = '0;
        case (lh_to_reg)
            2'b01:   lh_dout = lo;
            2'b10:   lh_dout = hi;
            default: lh_dout = '0;
        endcase
    end

endmodule
